// File: rtl/pc_unit.sv
// Program counter with priority next-address selection and a circular
// return-address stack that predicts the target of returns.
module pc_unit #(
    parameter int          ISIZE     = 16,
    parameter int unsigned RESET_VEC = 32'd0,
    parameter int unsigned STEP      = 32'd1,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_addr,
    input  logic             exc_valid,
    input  logic [ISIZE-1:0] exc_vec,
    input  logic             call,
    input  logic             ret,
    output logic [ISIZE-1:0] currPC,
    output logic [ISIZE-1:0] nextPC,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ISIZE-1:0] currpc_r;
    logic [ISIZE-1:0] ras_r [RAS_DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [CW-1:0]    count_r;

    logic [ISIZE-1:0] seq_s;
    logic [ISIZE-1:0] top_s;
    logic [ISIZE-1:0] next_s;
    logic [PW-1:0]    top_idx_s;
    logic             act_s;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             do_swap_s;

    // Next-address selection and stack operation decode.
    always_comb begin
        seq_s     = currpc_r + ISIZE'(STEP);
        top_idx_s = ptr_r - PW'(1);
        top_s     = ras_r[top_idx_s];
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == CW'(RAS_DEPTH));
        act_s     = ~exc_valid & ~redirect_valid & ~stall;
        // call+ret on a non-empty stack replaces the top in place
        do_swap_s = act_s & call & ret & ~empty_s;
        do_push_s = act_s & call & ~do_swap_s;
        do_pop_s  = act_s & ret & ~call & ~empty_s;
        next_s    = seq_s;
        if (exc_valid) begin
            next_s = exc_vec;
        end else if (redirect_valid) begin
            next_s = redirect_addr;
        end else if (stall) begin
            next_s = currpc_r;
        end else if (ret && !empty_s) begin
            next_s = top_s;
        end else begin
            next_s = seq_s;
        end
    end

    // PC register, stack pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            currpc_r <= ISIZE'(RESET_VEC);
            ptr_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            currpc_r <= next_s;
            if (exc_valid) begin
                ptr_r   <= {PW{1'b0}};
                count_r <= {CW{1'b0}};
            end else if (do_push_s) begin
                // when full, the write slot holds the oldest entry
                ptr_r   <= ptr_r + PW'(1);
                count_r <= full_s ? count_r : count_r + CW'(1);
            end else if (do_pop_s) begin
                ptr_r   <= top_idx_s;
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Stack storage; contents are never observable while empty, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && do_swap_s) begin
            ras_r[top_idx_s] <= seq_s;
        end else if (!rst && do_push_s) begin
            ras_r[ptr_r] <= seq_s;
        end
    end

    assign currPC    = currpc_r;
    assign nextPC    = next_s;
    assign ras_empty = empty_s;
    assign ras_full  = full_s;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        exc_valid;
    logic [15:0] exc_vec;
    logic        call;
    logic        ret;
    logic [15:0] currPC;
    logic [15:0] nextPC;
    logic        ras_empty;
    logic        ras_full;

    int tests_run;
    int tests_failed;

    pc_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .exc_valid(exc_valid),
        .exc_vec(exc_vec),
        .call(call),
        .ret(ret),
        .currPC(currPC),
        .nextPC(nextPC),
        .ras_empty(ras_empty),
        .ras_full(ras_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] addr);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic do_call();
        call = 1'b1;
        step();
        call = 1'b0;
    endtask

    task automatic do_ret();
        ret = 1'b1;
        step();
        ret = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        exc_valid      = 1'b0;
        exc_vec        = 16'h0000;
        call           = 1'b0;
        ret            = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_pc", currPC, 32'h0000);
        check("reset_empty", ras_empty, 32'h1);
        check("reset_full", ras_full, 32'h0);
        check("reset_next", nextPC, 32'h0001);

        // idle sequential fetch
        for (int i = 1; i <= 3; i++) begin
            step();
            check("idle_pc", currPC, i);
        end
        check("idle_empty", ras_empty, 32'h1);

        // single call / return
        go(16'h0010);
        do_call();
        check("call_pc", currPC, 32'h0011);
        check("call_nonempty", ras_empty, 32'h0);
        go(16'h0100);
        check("redir_pc", currPC, 32'h0100);
        go(16'h0105);
        ret = 1'b1;
        #1;
        check("ret_next", nextPC, 32'h0011);
        step();
        ret = 1'b0;
        check("ret_pc", currPC, 32'h0011);
        check("ret_empty", ras_empty, 32'h1);

        // five nested calls overflow a depth-4 stack
        for (int i = 1; i <= 5; i++) begin
            go(16'(i * 16));
            do_call();
        end
        check("nest_full", ras_full, 32'h1);
        check("nest_empty", ras_empty, 32'h0);
        do_ret();
        check("pop1", currPC, 32'h0051);
        check("pop1_full", ras_full, 32'h0);
        do_ret();
        check("pop2", currPC, 32'h0041);
        do_ret();
        check("pop3", currPC, 32'h0031);
        do_ret();
        check("pop4", currPC, 32'h0021);
        check("pop4_empty", ras_empty, 32'h1);
        do_ret();
        check("pop5_seq", currPC, 32'h0022);
        check("pop5_empty", ras_empty, 32'h1);

        // exception beats everything and clears the stack
        do_call();
        check("pre_exc_nonempty", ras_empty, 32'h0);
        exc_valid      = 1'b1;
        exc_vec        = 16'h0F00;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0200;
        stall          = 1'b1;
        ret            = 1'b1;
        #1;
        check("exc_next", nextPC, 32'h0F00);
        step();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        ret            = 1'b0;
        check("exc_pc", currPC, 32'h0F00);
        check("exc_empty", ras_empty, 32'h1);

        // wrap-around
        go(16'hFFFF);
        step();
        check("wrap_pc", currPC, 32'h0000);

        // stall holds PC and stack
        go(16'h0040);
        do_call();
        stall = 1'b1;
        call  = 1'b1;
        ret   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", currPC, 32'h0041);
        end
        stall = 1'b0;
        call  = 1'b0;
        ret   = 1'b0;
        check("stall_nonempty", ras_empty, 32'h0);
        go(16'h0080);
        do_ret();
        check("stall_ret_pc", currPC, 32'h0041);
        check("stall_ret_empty", ras_empty, 32'h1);

        // call+ret together replaces the top
        go(16'h0030);
        do_call();
        go(16'h0070);
        call = 1'b1;
        ret  = 1'b1;
        step();
        call = 1'b0;
        ret  = 1'b0;
        check("swap_pc", currPC, 32'h0031);
        check("swap_nonempty", ras_empty, 32'h0);
        check("swap_notfull", ras_full, 32'h0);
        do_ret();
        check("swap_top", currPC, 32'h0071);
        check("swap_empty", ras_empty, 32'h1);

        // call+ret on empty stack acts as a call
        go(16'h0090);
        call = 1'b1;
        ret  = 1'b1;
        step();
        call = 1'b0;
        ret  = 1'b0;
        check("cr_empty_pc", currPC, 32'h0091);
        check("cr_empty_push", ras_empty, 32'h0);

        // reset mid-sequence with full stack and stall
        for (int i = 0; i < 4; i++) begin
            do_call();
        end
        check("pre_rst_full", ras_full, 32'h1);
        stall = 1'b1;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        check("mid_rst_pc", currPC, 32'h0000);
        check("mid_rst_empty", ras_empty, 32'h1);
        check("mid_rst_full", ras_full, 32'h0);
        ret = 1'b1;
        #1;
        check("mid_rst_next", nextPC, 32'h0001);
        step();
        ret = 1'b0;
        check("post_rst_pc", currPC, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter ISIZE, default 16, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_VEC, default 0, giving the PC value loaded by reset.
REQ-003 The block SHALL have parameter STEP, default 1, giving the sequential increment.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4 (power of two, >=2), giving the return-address-stack entry count.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold PC and RAS when high.
REQ-008 redirect_valid  input  1  resolved branch/jump this cycle.
REQ-009 redirect_addr  input  ISIZE  branch/jump target.
REQ-010 exc_valid  input  1  exception/interrupt request.
REQ-011 exc_vec  input  ISIZE  exception handler address.
REQ-012 call  input  1  instruction at currPC is a call.
REQ-013 ret  input  1  instruction at currPC is a return.
REQ-014 currPC  output  ISIZE  registered current fetch address.
REQ-015 nextPC  output  ISIZE  combinational address currPC takes at the next edge.
REQ-016 ras_empty  output  1  RAS holds zero entries.
REQ-017 ras_full  output  1  RAS holds RAS_DEPTH entries.

Function
REQ-018 nextPC selection SHALL follow strict priority: exc_valid -> exc_vec; else redirect_valid -> redirect_addr; else stall -> currPC; else ret with RAS non-empty -> RAS top; else currPC+STEP.
REQ-019 currPC SHALL load nextPC on every rising edge when rst is low; latency from any input to currPC is one cycle.
REQ-020 currPC+STEP SHALL wrap modulo 2^ISIZE with no carry flag.
REQ-021 call and ret SHALL act only when exc_valid, redirect_valid and stall are all low.
REQ-022 call alone SHALL push currPC+STEP; count increments.
REQ-023 call with RAS full SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_full stays high.
REQ-024 ret alone with RAS non-empty SHALL pop the top entry; count decrements.
REQ-025 ret with RAS empty SHALL be ignored: nextPC = currPC+STEP, RAS unchanged.
REQ-026 call and ret together with RAS non-empty SHALL target the old top and replace it with currPC+STEP; count unchanged.
REQ-027 call and ret together with RAS empty SHALL behave as call alone (push, sequential nextPC).
REQ-028 exc_valid SHALL clear the RAS (count 0) at the same edge currPC loads exc_vec.
REQ-029 redirect_valid without exc_valid SHALL leave RAS contents and count unchanged.
REQ-030 ras_empty and ras_full SHALL be decoded from the registered count, never both high.

Reset
REQ-031 With rst high at a rising edge, currPC SHALL become RESET_VEC and the RAS count 0, overriding every other input.
REQ-032 After reset, ras_empty SHALL be 1, ras_full 0; RAS entry contents are don't-care and never observable.
REQ-033 rst asserted mid-sequence (e.g. stall or full RAS) SHALL discard all pending state at that edge; the first post-reset nextPC is RESET_VEC+STEP absent other inputs.

Verification (ISIZE=16, STEP=1, RESET_VEC=0, RAS_DEPTH=4)
REQ-034 Reset then 3 idle cycles -> currPC 0,1,2,3; ras_empty=1.
REQ-035 currPC=0x0010, call, redirect_addr=0x0100 next cycle; later ret at 0x0105 -> currPC 0x0011, RAS empty again.
REQ-036 Five nested calls from 0x10,0x20,0x30,0x40,0x50 -> ras_full=1; four rets return 0x51,0x41,0x31,0x21; fifth ret -> sequential, ras_empty=1.
REQ-037 exc_valid, redirect_valid, stall, ret all high, exc_vec=0x0F00 -> currPC 0x0F00, RAS cleared.
REQ-038 currPC=0xFFFF idle -> currPC 0x0000; stall held 3 cycles -> currPC constant, RAS unchanged despite call/ret.
REQ-039 RAS holding 0x0031, call+ret at 0x0070 -> currPC 0x0031, top becomes 0x0071, count unchanged.
